// File: rtl/instr_encoder.sv
// Packs loader-supplied instruction fields into 32-bit MIPS words and streams them,
// with ascending word addresses, to the instruction-memory write port.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target26,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       instr_word,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   word_count,
  output logic              err,
  output logic              done
);

  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   L_MAX  = (ADDR_W + 1)'(MAX_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FULL
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_nextAddr;
  logic [31:0]         w_word;
  logic                w_legal;
  logic                w_accept;
  logic [ADDR_W:0]     w_countInc;

  // Field packing mirrors the decoder; unused fields (rs for sll/lui, shamt for add/or) are forced to zero.
  always_comb begin
    w_word  = 32'h0000_0000;
    w_legal = 1'b1;
    case (op_sel)
      4'd0:    w_word = {6'h00, 5'd0, rt, rd, shamt, 6'h00};
      4'd1:    w_word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd2:    w_word = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4'd3:    w_word = {6'h02, target26};
      4'd4:    w_word = {6'h03, target26};
      4'd5:    w_word = {6'h04, rs, rt, imm16};
      4'd6:    w_word = {6'h05, rs, rt, imm16};
      4'd7:    w_word = {6'h08, rs, rt, imm16};
      4'd8:    w_word = {6'h0C, rs, rt, imm16};
      4'd9:    w_word = {6'h0D, rs, rt, imm16};
      4'd10:   w_word = {6'h0F, 5'd0, rt, imm16};
      4'd11:   w_word = {6'h23, rs, rt, imm16};
      4'd12:   w_word = {6'h2B, rs, rt, imm16};
      default: w_legal = 1'b0;
    endcase
  end

  assign in_ready   = (r_state == ST_RUN) && (!out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_countInc = word_count + 1'b1;

  // start wins over a same-cycle accept, so its fields are simply never looked at.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_nextAddr <= L_BASE;
      instr_word <= 32'h0000_0000;
      instr_addr <= '0;
      out_valid  <= 1'b0;
      word_count <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else if (start) begin
      r_state    <= ST_RUN;
      r_nextAddr <= L_BASE;
      out_valid  <= 1'b0;
      word_count <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (w_accept && w_legal) begin
        instr_word <= w_word;
        instr_addr <= r_nextAddr;
        out_valid  <= 1'b1;
        r_nextAddr <= r_nextAddr + 1'b1;
        if (word_count != L_MAX) begin
          word_count <= w_countInc;
        end
        if (w_countInc >= L_MAX) begin
          r_state <= ST_FULL;
          done    <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_accept && !w_legal) begin
        err <= 1'b1;
      end
    end
  end

endmodule
